// File: rtl/debounce_filter.sv
// Debounces an already-synchronised level: dout follows din only after din has
// differed from dout for STABLE_CNT consecutive samples, with one-clock edge pulses.
module debounce_filter #(
   parameter int unsigned STABLE_CNT  = 4,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned   CW   = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

   typedef enum logic {S_STABLE, S_PEND} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_STABLE;
         cnt   <= '0;
         dout  <= RESET_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            S_STABLE: begin
               if (din != dout) begin
                  // a single-sample filter accepts immediately and never counts
                  if (STABLE_CNT == 1) begin
                     dout <= din;
                     rise <= din;
                     fall <= ~din;
                  end else begin
                     state <= S_PEND;
                     busy  <= 1'b1;
                     cnt   <= CW'(1);
                  end
               end
            end
            S_PEND: begin
               if (din == dout) begin
                  state <= S_STABLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  dout  <= din;
                  rise  <= din;
                  fall  <= ~din;
                  state <= S_STABLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_STABLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: STABLE_CNT=4 and STABLE_CNT=1 instances checked
// every cycle against a run-length reference model plus directed scenarios.
module tb_debounce_filter;

   logic       clk = 1'b0;
   logic [1:0] rst_v, din_v;
   logic [1:0] dout_w, rise_w, fall_w, busy_w;

   int n_chk = 0;
   int n_fail = 0;

   int unsigned n_req[2] = '{4, 1};
   bit m_dout[2], m_rise[2], m_fall[2], m_busy[2];
   int m_run[2];

   bit samp1, rst1, prev1;
   int chg1 = 0, pulses1 = 0;

   always #5 clk = ~clk;

   debounce_filter #(.STABLE_CNT(4), .RESET_LEVEL(1'b0)) u_d4 (
      .clk(clk), .rst(rst_v[0]), .din(din_v[0]),
      .dout(dout_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .busy(busy_w[0]));

   debounce_filter #(.STABLE_CNT(1), .RESET_LEVEL(1'b0)) u_d1 (
      .clk(clk), .rst(rst_v[1]), .din(din_v[1]),
      .dout(dout_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .busy(busy_w[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: count consecutive samples that disagree with the output level
   task automatic tick();
      @(posedge clk);
      samp1 = din_v[1];
      rst1  = rst_v[1];
      for (int i = 0; i < 2; i++) begin
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (rst_v[i]) begin
            m_dout[i] = 1'b0;
            m_run[i]  = 0;
            m_busy[i] = 1'b0;
         end else if (din_v[i] != m_dout[i]) begin
            m_run[i]++;
            if (m_run[i] >= int'(n_req[i])) begin
               m_dout[i] = din_v[i];
               m_rise[i] = din_v[i];
               m_fall[i] = ~din_v[i];
               m_run[i]  = 0;
               m_busy[i] = 1'b0;
            end else begin
               m_busy[i] = 1'b1;
            end
         end else begin
            m_run[i]  = 0;
            m_busy[i] = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d_dout", n_req[i]), 32'(dout_w[i]), 32'(m_dout[i]));
         chk($sformatf("d%0d_rise", n_req[i]), 32'(rise_w[i]), 32'(m_rise[i]));
         chk($sformatf("d%0d_fall", n_req[i]), 32'(fall_w[i]), 32'(m_fall[i]));
         chk($sformatf("d%0d_busy", n_req[i]), 32'(busy_w[i]), 32'(m_busy[i]));
         chk($sformatf("d%0d_excl", n_req[i]), 32'(rise_w[i] & fall_w[i]), 32'd0);
      end
      if (rst1) begin
         prev1 = 1'b0;
      end else begin
         chk("d1_delay", 32'(dout_w[1]), 32'(samp1));
         chk("d1_busy0", 32'(busy_w[1]), 32'd0);
         if (samp1 != prev1) chg1++;
         prev1 = samp1;
      end
      if (rise_w[1] | fall_w[1]) pulses1++;
      din_v[1] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int total;
      int len;
      bit val;
      rst_v = 2'b11;
      din_v = 2'b01;
      tick();
      tick();
      chk("rst_dout", 32'(dout_w[0]), 32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_rise", 32'(rise_w[0]), 32'd0);
      rst_v[1] = 1'b0;

      // release with din=1: rise on the 4th edge
      rst_v[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rel_hold", 32'(dout_w[0]), 32'd0);
      end
      tick();
      chk("rel_dout", 32'(dout_w[0]), 32'd1);
      chk("rel_rise", 32'(rise_w[0]), 32'd1);
      tick();
      chk("rel_rise_end", 32'(rise_w[0]), 32'd0);

      // from 1, hold 0: fall on the 4th sampling edge
      din_v[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fall_hold", 32'(dout_w[0]), 32'd1);
         chk("fall_busy", 32'(busy_w[0]), 32'd1);
      end
      tick();
      chk("fall_pulse", 32'(fall_w[0]), 32'd1);
      chk("fall_dout", 32'(dout_w[0]), 32'd0);

      // toggling every clock never survives the filter
      for (int k = 0; k < 20; k++) begin
         din_v[0] = ~din_v[0];
         tick();
         chk("tog_dout", 32'(dout_w[0]), 32'd0);
         chk("tog_pulse", 32'(rise_w[0] | fall_w[0]), 32'd0);
      end
      din_v[0] = 1'b0;
      tick();
      tick();

      // 3-sample excursion rejected
      din_v[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("exc_busy", 32'(busy_w[0]), 32'd1);
      end
      din_v[0] = 1'b0;
      tick();
      chk("exc_busy_end", 32'(busy_w[0]), 32'd0);
      chk("exc_dout", 32'(dout_w[0]), 32'd0);
      chk("exc_rise", 32'(rise_w[0]), 32'd0);

      // reset mid-count discards progress
      din_v[0] = 1'b1;
      tick();
      tick();
      rst_v[0] = 1'b1;
      tick();
      chk("mid_rst_dout", 32'(dout_w[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
      chk("mid_rst_rise", 32'(rise_w[0]), 32'd0);
      tick();
      rst_v[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_hold", 32'(dout_w[0]), 32'd0);
      end
      tick();
      chk("mid_rise", 32'(rise_w[0]), 32'd1);

      // change right after acceptance starts a fresh count
      din_v[0] = 1'b0;
      tick();
      chk("fresh_busy", 32'(busy_w[0]), 32'd1);
      tick();
      tick();
      chk("fresh_hold", 32'(dout_w[0]), 32'd1);
      tick();
      chk("fresh_fall", 32'(fall_w[0]), 32'd1);

      // random run lengths with rare resets
      total = 0;
      while (total < 10000) begin
         len = int'($urandom_range(1, 10));
         val = 1'($urandom_range(0, 1));
         for (int k = 0; k < len; k++) begin
            din_v[0] = val;
            rst_v[0] = ($urandom_range(0, 499) == 0);
            tick();
            total++;
         end
      end
      rst_v[0] = 1'b0;

      chk("d1_pulses", 32'(pulses1), 32'(chg1));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
